// File: rtl/wallace_pkg.sv
// Shared constants, carry-save types and helpers for the pipelined Wallace-tree multiplier.
package wallace_pkg;

  localparam int unsigned PIPE_STAGES = 3;
  localparam int unsigned LATENCY     = PIPE_STAGES;

  // One column of a carry-save pair; an N-bit row pair is cs_col_t [N-1:0].
  typedef struct packed {
    logic sum;
    logic carry;
  } cs_col_t;

  // Number of 3:2 levels needed to bring `rows` operands down to two.
  function automatic int unsigned csa_levels(int unsigned rows);
    int unsigned n;
    int unsigned lvl;
    n   = rows;
    lvl = 0;
    for (int k = 0; k < 64; k++) begin
      if (n > 2) begin
        n   = 2 * (n / 3) + (n % 3);
        lvl = lvl + 1;
      end
    end
    return lvl;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder, sum truncated to N bits; final add of the multiplier pipeline.
module ripple_carry_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  always_comb begin : ripple
    logic c;
    c     = 1'b0;
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with valid/ready on both sides and a tag.
// Define SIGNED_MODE_EN to honour sgn_i (Baugh-Wooley two's-complement products).
module wallace_mult_pipe #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               sgn_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  import wallace_pkg::*;

  localparam int unsigned RowW = 2 * WIDTH;
`ifdef SIGNED_MODE_EN
  // Extra row carries the Baugh-Wooley correction constant.
  localparam int unsigned NumRows = WIDTH + 1;
`else
  localparam int unsigned NumRows = WIDTH;
`endif
  localparam int unsigned Levels = csa_levels(NumRows);

  function automatic void csa32(input  logic [RowW-1:0] x,
                                input  logic [RowW-1:0] y,
                                input  logic [RowW-1:0] z,
                                output logic [RowW-1:0] s,
                                output logic [RowW-1:0] c);
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Handshake / stage-advance chain
  logic v1_q, v2_q, v3_q;
  logic s1_load, s2_load, s3_load;
  logic in_fire;

  assign s3_load    = !v3_q || out_ready_i;
  assign s2_load    = !v2_q || s3_load;
  assign s1_load    = !v1_q || s2_load;
  assign in_ready_o = s1_load && rst_n;
  assign in_fire    = in_valid_i && in_ready_o;

  // S1: operand capture
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;
`ifdef SIGNED_MODE_EN
  logic             s1_sgn_q;
`else
  logic             unused_sgn;
  assign unused_sgn = sgn_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_tag_q <= '0;
`ifdef SIGNED_MODE_EN
      s1_sgn_q <= 1'b0;
`endif
    end else begin
      if (s1_load) v1_q <= in_fire;
      if (in_fire) begin
        s1_a_q   <= a_i;
        s1_b_q   <= b_i;
        s1_tag_q <= in_tag_i;
`ifdef SIGNED_MODE_EN
        s1_sgn_q <= sgn_i;
`endif
      end
    end
  end

  // S2: partial products and Wallace reduction to a carry-save pair
  cs_col_t [RowW-1:0] s2_cs_d, s2_cs_q;
  logic [TAG_W-1:0]   s2_tag_q;

  always_comb begin : wallace_reduce
    logic [RowW-1:0]  cur [NumRows];
    logic [RowW-1:0]  nxt [NumRows];
    logic [WIDTH-1:0] pp;
    logic [RowW-1:0]  s, c;
    int               n, ng, rem;

    for (int i = 0; i < WIDTH; i++) begin
      pp = s1_a_q & {WIDTH{s1_b_q[i]}};
`ifdef SIGNED_MODE_EN
      // Complement every term pairing exactly one sign bit.
      if (s1_sgn_q) begin
        if (i == WIDTH - 1) pp = pp ^ {1'b0, {(WIDTH-1){1'b1}}};
        else                pp = pp ^ {1'b1, {(WIDTH-1){1'b0}}};
      end
`endif
      cur[i] = RowW'(pp) << i;
    end
`ifdef SIGNED_MODE_EN
    cur[WIDTH] = s1_sgn_q ? ((RowW'(1) << WIDTH) | (RowW'(1) << (RowW - 1))) : '0;
`endif

    n = NumRows;
    s = '0;
    c = '0;
    for (int l = 0; l < Levels; l++) begin
      nxt = '{default: '0};
      ng  = n / 3;
      rem = n % 3;
      for (int g = 0; g < NumRows / 3; g++) begin
        if (g < ng) begin
          csa32(cur[3*g], cur[3*g+1], cur[3*g+2], s, c);
          nxt[2*g]   = s;
          nxt[2*g+1] = c;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < rem) nxt[2*ng+r] = cur[3*ng+r];
      end
      n   = 2 * ng + rem;
      cur = nxt;
    end

    s2_cs_d = '0;
    for (int k = 0; k < RowW; k++) begin
      s2_cs_d[k].sum   = cur[0][k];
      s2_cs_d[k].carry = cur[1][k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      s2_cs_q  <= '0;
      s2_tag_q <= '0;
    end else begin
      if (s2_load) v2_q <= v1_q;
      if (s2_load && v1_q) begin
        s2_cs_q  <= s2_cs_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  // S3: ripple-carry final add
  logic [RowW-1:0]  s3_sum_row, s3_carry_row, s3_result_d;
  logic [RowW-1:0]  result_q;
  logic [TAG_W-1:0] out_tag_q;

  always_comb begin
    s3_sum_row   = '0;
    s3_carry_row = '0;
    for (int k = 0; k < RowW; k++) begin
      s3_sum_row[k]   = s2_cs_q[k].sum;
      s3_carry_row[k] = s2_cs_q[k].carry;
    end
  end

  ripple_carry_adder #(
    .N (RowW)
  ) u_final_add (
    .a_i   (s3_sum_row),
    .b_i   (s3_carry_row),
    .sum_o (s3_result_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q      <= 1'b0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      if (s3_load) v3_q <= v2_q;
      if (s3_load && v2_q) begin
        result_q  <= s3_result_d;
        out_tag_q <= s2_tag_q;
      end
    end
  end

  assign out_valid_o = v3_q;
  assign result_o    = result_q;
  assign out_tag_o   = out_tag_q;

endmodule
